// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: state encoding, default widths
// and the round-robin pointer helper.
package shared_reg_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Index of the requester following idx, wrapping n-1 back to 0.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester at or above ptr wins,
// wrapping past NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win,
  output logic               any
);

  // Scan from the farthest offset down, so the closest requester to ptr overwrites last.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        win = IDX_W'((int'(ptr) + k) % NUM_REQ);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin sequencer for one shared register: grants a single read or write per
// two-cycle slot, so accesses never collide on the same edge.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int                NUM_REQ   = DEF_NUM_REQ,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [IDX_W-1:0]          rid,
  output logic [DATA_W-1:0]         shared_q,
  output logic                      busy
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   win_q;
  logic               we_q;
  logic [DATA_W-1:0]  wdata_q;

  logic [IDX_W-1:0]   pick_win;
  logic               pick_any;
  logic [DATA_W-1:0]  sel_wdata;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .win (pick_win),
    .any (pick_any)
  );

  assign sel_wdata = wdata[int'(pick_win)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pick_any) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The winner's we/wdata are frozen at the selecting edge; anything the requester
  // does while the access is in flight has no effect on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rid      <= '0;
      shared_q <= RESET_VAL;
      ptr_q    <= '0;
      win_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      gnt    <= '0;
      rvalid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            win_q   <= pick_win;
            we_q    <= we[pick_win];
            wdata_q <= sel_wdata;
            gnt     <= NUM_REQ'(1) << pick_win;
          end
        end
        ST_ACCESS: begin
          if (we_q) begin
            shared_q <= wdata_q;
          end else begin
            rdata  <= shared_q;
            rid    <= win_q;
            rvalid <= 1'b1;
          end
          ptr_q <= IDX_W'(next_idx(int'(win_q), NUM_REQ));
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == ST_ACCESS);

endmodule
